// File: rtl/sprite_blitter_if.sv
// Bus bundle for sprite_blitter: draw-queue head, sprite storage read port and
// framebuffer write port. The blitter connects through the master modport.
interface sprite_blitter_if #(
  parameter int SPRITE_NUM = 16,
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int FB_W       = 320,
  parameter int FB_H       = 240
);
  localparam int SEL_W  = $clog2(SPRITE_NUM);
  localparam int SRC_AW = $clog2(SPRITE_W * SPRITE_H);
  localparam int FB_AW  = $clog2(FB_W * FB_H);

  logic              queue_empty;
  logic              dequeue;
  logic [7:0]        q_sprite_id;
  logic [15:0]       q_x;
  logic [15:0]       q_y;
  logic [7:0]        q_scale;
  logic [SEL_W-1:0]  sprite_select;
  logic              sprite_r_en;
  logic [SRC_AW-1:0] sprite_r_addr;
  logic [3:0]        sprite_r_data;
  logic              fb_w_en;
  logic [FB_AW-1:0]  fb_w_addr;
  logic [3:0]        fb_w_data;
  logic              fb_w_ready;

  modport master (
    input  queue_empty, q_sprite_id, q_x, q_y, q_scale, sprite_r_data, fb_w_ready,
    output dequeue, sprite_select, sprite_r_en, sprite_r_addr, fb_w_en, fb_w_addr, fb_w_data
  );

  modport slave (
    output queue_empty, q_sprite_id, q_x, q_y, q_scale, sprite_r_data, fb_w_ready,
    input  dequeue, sprite_select, sprite_r_en, sprite_r_addr, fb_w_en, fb_w_addr, fb_w_data
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: pops draw commands and writes scaled, clipped, non-transparent
// sprite pixels to the framebuffer. Define SPRITE_BLITTER_HFLIP_EN for q_scale[7] mirroring.
module sprite_blitter #(
  parameter int SPRITE_NUM      = 16,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int FB_W            = 320,
  parameter int FB_H            = 240,
  parameter int MAX_SCALE       = 4,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic             sys_clock,
  input  logic             reset,
  sprite_blitter_if.master bus,
  output logic             busy,
  output logic             sprite_done
);
  localparam int SEL_W  = $clog2(SPRITE_NUM);
  localparam int SRC_AW = $clog2(SPRITE_W * SPRITE_H);
  localparam int FB_AW  = $clog2(FB_W * FB_H);
  localparam int SX_W   = $clog2(SPRITE_W);
  localparam int SY_W   = $clog2(SPRITE_H);
  localparam int DX_W   = $clog2(SPRITE_W * MAX_SCALE);
  localparam int DY_W   = $clog2(SPRITE_H * MAX_SCALE);
  localparam int SC_W   = $clog2(MAX_SCALE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic              dequeue_r;
  logic              sprite_done_r;
  logic [15:0]       x_r;
  logic [15:0]       y_r;
  logic [SEL_W-1:0]  id_r;
  logic [SC_W-1:0]   s_last;
  logic [DX_W-1:0]   dx_last;
  logic [DY_W-1:0]   dy_last;
  logic [DX_W-1:0]   dx;
  logic [DY_W-1:0]   dy;
  logic [SX_W-1:0]   sx;
  logic [SY_W-1:0]   sy;
  logic [SC_W-1:0]   subx;
  logic [SC_W-1:0]   suby;
  logic              stage_valid;
  logic              stage_clip;
  logic [FB_AW-1:0]  stage_addr;

  logic [2:0]        scale_raw;
  logic [SC_W-1:0]   scale_c;
  logic [16:0]       px;
  logic [16:0]       py;
  logic              clip;
  logic [FB_AW-1:0]  pix_addr;
  logic [SX_W-1:0]   src_col;
  logic              wr_en;
  logic              stall;
  logic              rd;

  always_comb begin
    scale_raw = bus.q_scale[2:0];
    if (scale_raw == 3'd0)
      scale_c = SC_W'(1);
    else if (32'(scale_raw) > MAX_SCALE)
      scale_c = SC_W'(MAX_SCALE);
    else
      scale_c = SC_W'(scale_raw);
  end

  // Destination position and clip use 17-bit signed math so negative origins never wrap.
  always_comb begin
    px       = {x_r[15], x_r} + 17'(dx);
    py       = {y_r[15], y_r} + 17'(dy);
    clip     = px[16] || py[16] || (px[15:0] >= 16'(FB_W)) || (py[15:0] >= 16'(FB_H));
    pix_addr = FB_AW'(32'(py[15:0]) * 32'(FB_W) + 32'(px[15:0]));
  end

`ifdef SPRITE_BLITTER_HFLIP_EN
  logic flip_r;
  logic unused_scale_bits;
  assign unused_scale_bits = ^bus.q_scale[6:3];
  assign src_col = flip_r ? (SX_W'(SPRITE_W - 1) - sx) : sx;
`else
  logic unused_scale_bits;
  assign unused_scale_bits = ^bus.q_scale[7:3];
  assign src_col = sx;
`endif

  assign wr_en = stage_valid && !stage_clip && (bus.sprite_r_data != 4'(TRANSPARENT_IDX));
  assign stall = wr_en && !bus.fb_w_ready;
  // The first RUN cycle overlaps the dequeue pulse, so reads start one cycle later.
  assign rd    = (state == RUN) && !dequeue_r && !stall;

  assign bus.dequeue       = dequeue_r;
  assign bus.sprite_select = id_r;
  assign bus.sprite_r_en   = rd;
  assign bus.sprite_r_addr = SRC_AW'({sy, src_col});
  assign bus.fb_w_en       = wr_en;
  assign bus.fb_w_addr     = stage_addr;
  assign bus.fb_w_data     = stage_valid ? bus.sprite_r_data : '0;
  assign busy              = (state != IDLE);
  assign sprite_done       = sprite_done_r;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dequeue_r     <= 1'b0;
      sprite_done_r <= 1'b0;
      x_r           <= '0;
      y_r           <= '0;
      id_r          <= '0;
      s_last        <= '0;
      dx_last       <= '0;
      dy_last       <= '0;
      dx            <= '0;
      dy            <= '0;
      sx            <= '0;
      sy            <= '0;
      subx          <= '0;
      suby          <= '0;
      stage_valid   <= 1'b0;
      stage_clip    <= 1'b0;
      stage_addr    <= '0;
`ifdef SPRITE_BLITTER_HFLIP_EN
      flip_r        <= 1'b0;
`endif
    end else begin
      dequeue_r     <= 1'b0;
      sprite_done_r <= 1'b0;
      if (!stall)
        stage_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.queue_empty) begin
            dequeue_r <= 1'b1;
            x_r       <= bus.q_x;
            y_r       <= bus.q_y;
            id_r      <= SEL_W'(bus.q_sprite_id);
            s_last    <= scale_c - SC_W'(1);
            dx_last   <= DX_W'(SPRITE_W * int'(scale_c) - 1);
            dy_last   <= DY_W'(SPRITE_H * int'(scale_c) - 1);
            dx        <= '0;
            dy        <= '0;
            sx        <= '0;
            sy        <= '0;
            subx      <= '0;
            suby      <= '0;
`ifdef SPRITE_BLITTER_HFLIP_EN
            flip_r    <= bus.q_scale[7];
`endif
            if (32'(bus.q_sprite_id) >= SPRITE_NUM) begin
              state         <= DONE;
              sprite_done_r <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (rd) begin
            stage_valid <= 1'b1;
            stage_clip  <= clip;
            stage_addr  <= clip ? '0 : pix_addr;
            if (dx == dx_last) begin
              dx   <= '0;
              sx   <= '0;
              subx <= '0;
              dy   <= dy + DY_W'(1);
              if (suby == s_last) begin
                suby <= '0;
                sy   <= sy + SY_W'(1);
              end else begin
                suby <= suby + SC_W'(1);
              end
              if (dy == dy_last)
                state <= DRAIN;
            end else begin
              dx <= dx + DX_W'(1);
              if (subx == s_last) begin
                subx <= '0;
                sx   <= sx + SX_W'(1);
              end else begin
                subx <= subx + SC_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            state         <= DONE;
            sprite_done_r <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
